// File: rtl/mips_pkg.sv
// Shared constants for the MIPS decode/execute slice: opcodes, ALU-control codes,
// ALUOp encodings, the main-control bundle and the two-level ALU-control decode.
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;

    typedef enum logic [3:0] {
        ALU_AND = 4'b0000,
        ALU_OR  = 4'b0001,
        ALU_ADD = 4'b0010,
        ALU_SUB = 4'b0110,
        ALU_SLT = 4'b0111,
        ALU_NOR = 4'b1100
    } alu_ctl_e;

    typedef enum logic [1:0] {
        ALUOP_MEM    = 2'b00,
        ALUOP_BRANCH = 2'b01,
        ALUOP_FUNCT  = 2'b10,
        ALUOP_RSVD   = 2'b11
    } alu_op_e;

    typedef struct packed {
        logic       reg_dst;
        logic       alu_src;
        logic       mem_to_reg;
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
        logic       branch_eq;
        logic       branch_ne;
        logic [1:0] alu_op;
    } ctrl_t;

    // I-type ALU ops masquerade as R-type funct nibbles so one table serves both.
    function automatic logic [3:0] alu_nibble(input logic [5:0] opcode,
                                              input logic [3:0] funct_lo);
        logic [3:0] nib;
        case (opcode)
            OP_ADDI: nib = 4'b0000;
            OP_ANDI: nib = 4'b0100;
            OP_ORI:  nib = 4'b0101;
            default: nib = funct_lo;
        endcase
        return nib;
    endfunction

    function automatic logic [3:0] alu_ctl_decode(input logic [1:0] alu_op,
                                                  input logic [3:0] nib);
        logic [3:0] ctl;
        ctl = ALU_ADD;
        case (alu_op)
            ALUOP_MEM:    ctl = ALU_ADD;
            ALUOP_BRANCH: ctl = ALU_SUB;
            ALUOP_FUNCT: begin
                case (nib)
                    4'b0000: ctl = ALU_ADD;
                    4'b0010: ctl = ALU_SUB;
                    4'b0100: ctl = ALU_AND;
                    4'b0101: ctl = ALU_OR;
                    4'b0111: ctl = ALU_NOR;
                    4'b1010: ctl = ALU_SLT;
                    default: ctl = ALU_ADD;
                endcase
            end
            default:      ctl = ALU_ADD;
        endcase
        return ctl;
    endfunction

endpackage

// File: rtl/alu_n.sv
// Purely combinational N-bit ALU: AND/OR/NOR/ADD/SUB/SLT with carry, signed
// overflow, signed less-than and zero flags.
module alu_n
    import mips_pkg::*;
#(
    parameter int unsigned N = 32
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic [3:0]   alu_ctl,
    output logic [N-1:0] result,
    output logic         cout,
    output logic         slt,
    output logic         overflow,
    output logic         zero
);

    logic [N:0] add_full;
    logic [N:0] sub_full;
    logic       add_ovf;
    logic       sub_ovf;

    assign add_full = {1'b0, a} + {1'b0, b};
    assign sub_full = {1'b0, a} + {1'b0, ~b} + {{N{1'b0}}, 1'b1};

    assign add_ovf = (a[N-1] == b[N-1]) && (add_full[N-1] != a[N-1]);
    assign sub_ovf = (a[N-1] != b[N-1]) && (sub_full[N-1] != a[N-1]);

    // Comparison is always computed from the subtractor, whatever op is selected.
    assign slt = sub_full[N-1] ^ sub_ovf;

    always_comb begin
        result   = '0;
        cout     = 1'b0;
        overflow = 1'b0;
        case (alu_ctl)
            ALU_AND: result = a & b;
            ALU_OR:  result = a | b;
            ALU_NOR: result = ~(a | b);
            ALU_ADD: begin
                result   = add_full[N-1:0];
                cout     = add_full[N];
                overflow = add_ovf;
            end
            ALU_SUB: begin
                result   = sub_full[N-1:0];
                cout     = sub_full[N];
                overflow = sub_ovf;
            end
            ALU_SLT: result = {{(N-1){1'b0}}, slt};
            default: result = '0;
        endcase
    end

    assign zero = (result == '0);

endmodule

// File: rtl/mips_ctrl_alu.sv
// Single-cycle MIPS main-control + ALU-control decode wrapped around alu_n, with a
// registered result/flag observation stage. Define STICKY_OVF_EN to add ovf_sticky.
module mips_ctrl_alu
    import mips_pkg::*;
#(
    parameter int unsigned N = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [5:0]   opcode,
    input  logic [5:0]   funct,
    input  logic [N-1:0] rs_data,
    input  logic [N-1:0] rt_data,
    input  logic [15:0]  imm16,
    output logic         reg_dst,
    output logic         alu_src,
    output logic         mem_to_reg,
    output logic         reg_write,
    output logic         mem_read,
    output logic         mem_write,
    output logic         branch_eq,
    output logic         branch_ne,
    output logic [1:0]   alu_op,
    output logic [3:0]   alu_ctl,
    output logic [N-1:0] imm_ext,
`ifdef STICKY_OVF_EN
    output logic         ovf_sticky,
`endif
    output logic [N-1:0] result,
    output logic         cout,
    output logic         slt,
    output logic         overflow,
    output logic         zero,
    output logic [N-1:0] result_q,
    output logic [3:0]   flags_q
);

    ctrl_t      ctrl;
    logic [3:0] nib;
    logic [N-1:0] operand_b;
    logic       unused_funct_hi;

    // Only the low funct nibble takes part in ALU-control decode.
    assign unused_funct_hi = ^funct[5:4];

    always_comb begin
        ctrl = '0;
        case (opcode)
            OP_RTYPE: begin
                ctrl.reg_dst   = 1'b1;
                ctrl.reg_write = 1'b1;
                ctrl.alu_op    = ALUOP_FUNCT;
            end
            OP_LW: begin
                ctrl.alu_src    = 1'b1;
                ctrl.mem_to_reg = 1'b1;
                ctrl.reg_write  = 1'b1;
                ctrl.mem_read   = 1'b1;
                ctrl.alu_op     = ALUOP_MEM;
            end
            OP_SW: begin
                ctrl.alu_src   = 1'b1;
                ctrl.mem_write = 1'b1;
                ctrl.alu_op    = ALUOP_MEM;
            end
            OP_BEQ: begin
                ctrl.branch_eq = 1'b1;
                ctrl.alu_op    = ALUOP_BRANCH;
            end
            OP_BNE: begin
                ctrl.branch_ne = 1'b1;
                ctrl.alu_op    = ALUOP_BRANCH;
            end
            OP_ADDI, OP_ANDI, OP_ORI: begin
                ctrl.alu_src   = 1'b1;
                ctrl.reg_write = 1'b1;
                ctrl.alu_op    = ALUOP_FUNCT;
            end
            default: ctrl = '0;
        endcase
    end

    assign reg_dst    = ctrl.reg_dst;
    assign alu_src    = ctrl.alu_src;
    assign mem_to_reg = ctrl.mem_to_reg;
    assign reg_write  = ctrl.reg_write;
    assign mem_read   = ctrl.mem_read;
    assign mem_write  = ctrl.mem_write;
    assign branch_eq  = ctrl.branch_eq;
    assign branch_ne  = ctrl.branch_ne;
    assign alu_op     = ctrl.alu_op;

    assign nib     = alu_nibble(opcode, funct[3:0]);
    assign alu_ctl = alu_ctl_decode(ctrl.alu_op, nib);

    assign imm_ext   = {{(N-16){imm16[15]}}, imm16};
    assign operand_b = ctrl.alu_src ? imm_ext : rt_data;

    alu_n #(
        .N(N)
    ) u_alu (
        .a        (rs_data),
        .b        (operand_b),
        .alu_ctl  (alu_ctl),
        .result   (result),
        .cout     (cout),
        .slt      (slt),
        .overflow (overflow),
        .zero     (zero)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            result_q <= '0;
            flags_q  <= '0;
        end else begin
            result_q <= result;
            flags_q  <= {cout, slt, overflow, zero};
        end
    end

`ifdef STICKY_OVF_EN
    logic ovf_sticky_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ovf_sticky_q <= 1'b0;
        end else if (overflow) begin
            ovf_sticky_q <= 1'b1;
        end
    end

    assign ovf_sticky = ovf_sticky_q;
`endif

endmodule

// File: tb/tb_mips_ctrl_alu.sv
// Directed-vector bench for mips_ctrl_alu with hand-computed expectations.
module tb_mips_ctrl_alu;

    localparam int unsigned N = 32;

    logic         clk;
    logic         rst;
    logic [5:0]   opcode;
    logic [5:0]   funct;
    logic [N-1:0] rs_data;
    logic [N-1:0] rt_data;
    logic [15:0]  imm16;
    logic         reg_dst, alu_src, mem_to_reg, reg_write, mem_read, mem_write;
    logic         branch_eq, branch_ne;
    logic [1:0]   alu_op;
    logic [3:0]   alu_ctl;
    logic [N-1:0] imm_ext;
    logic [N-1:0] result;
    logic         cout, slt, overflow, zero;
    logic [N-1:0] result_q;
    logic [3:0]   flags_q;
`ifdef STICKY_OVF_EN
    logic         ovf_sticky;
`endif

    int n_vec = 0;
    int n_err = 0;

    mips_ctrl_alu #(
        .N(N)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .opcode     (opcode),
        .funct      (funct),
        .rs_data    (rs_data),
        .rt_data    (rt_data),
        .imm16      (imm16),
        .reg_dst    (reg_dst),
        .alu_src    (alu_src),
        .mem_to_reg (mem_to_reg),
        .reg_write  (reg_write),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .branch_eq  (branch_eq),
        .branch_ne  (branch_ne),
        .alu_op     (alu_op),
        .alu_ctl    (alu_ctl),
        .imm_ext    (imm_ext),
`ifdef STICKY_OVF_EN
        .ovf_sticky (ovf_sticky),
`endif
        .result     (result),
        .cout       (cout),
        .slt        (slt),
        .overflow   (overflow),
        .zero       (zero),
        .result_q   (result_q),
        .flags_q    (flags_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Drive one instruction just after a falling edge and let it settle.
    task automatic apply(input logic [5:0] op, input logic [5:0] fn, input logic [31:0] a,
                         input logic [31:0] b, input logic [15:0] imm);
        @(negedge clk);
        opcode  = op;
        funct   = fn;
        rs_data = a;
        rt_data = b;
        imm16   = imm;
        #1;
    endtask

    task automatic next_edge();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b0;
        opcode = '0; funct = '0; rs_data = '0; rt_data = '0; imm16 = '0;
        #12;
        check("reset result_q", result_q, 32'h0);
        check("reset flags_q", {28'h0, flags_q}, 32'h0);

        apply(6'b000000, 6'b100000, 32'd7, 32'd5, 16'h0);
        rst = 1'b1;
        check("add alu_ctl", {28'h0, alu_ctl}, 32'h2);
        check("add result", result, 32'd12);
        check("add reg_dst", {31'h0, reg_dst}, 32'h1);
        check("add reg_write", {31'h0, reg_write}, 32'h1);
        check("add alu_op", {30'h0, alu_op}, 32'h2);
        check("add zero", {31'h0, zero}, 32'h0);
        next_edge();
        check("add result_q", result_q, 32'd12);
        check("add flags_q", {28'h0, flags_q}, 32'h0);

        apply(6'b000000, 6'b100010, 32'h8000_0000, 32'h1, 16'h0);
        check("sub result", result, 32'h7FFF_FFFF);
        check("sub overflow", {31'h0, overflow}, 32'h1);
        check("sub cout", {31'h0, cout}, 32'h1);
        check("sub slt", {31'h0, slt}, 32'h1);
        next_edge();
        check("sub flags_q", {28'h0, flags_q}, 32'hE);
`ifdef STICKY_OVF_EN
        check("sticky set", {31'h0, ovf_sticky}, 32'h1);
`endif

        apply(6'b100011, 6'b000000, 32'h100, 32'h0, 16'hFFFC);
        check("lw imm_ext", imm_ext, 32'hFFFF_FFFC);
        check("lw result", result, 32'hFC);
        check("lw ctrl", {26'h0, alu_src, mem_to_reg, reg_write, mem_read, mem_write, reg_dst},
              32'b111100);
        check("lw overflow", {31'h0, overflow}, 32'h0);

        apply(6'b101011, 6'b000000, 32'h200, 32'h1234, 16'h0008);
        check("sw result", result, 32'h208);
        check("sw ctrl", {26'h0, alu_src, mem_to_reg, reg_write, mem_read, mem_write, reg_dst},
              32'b100010);

        apply(6'b000100, 6'b000000, 32'h55, 32'h55, 16'h0);
        check("beq alu_ctl", {28'h0, alu_ctl}, 32'h6);
        check("beq zero", {31'h0, zero}, 32'h1);
        check("beq branch", {30'h0, branch_eq, branch_ne}, 32'h2);
        check("beq alu_op", {30'h0, alu_op}, 32'h1);

        apply(6'b000101, 6'b000000, 32'h55, 32'h54, 16'h0);
        check("bne branch", {30'h0, branch_eq, branch_ne}, 32'h1);
        check("bne zero", {31'h0, zero}, 32'h0);

        apply(6'b000000, 6'b101010, 32'hFFFF_FFFF, 32'h1, 16'h0);
        check("slt alu_ctl", {28'h0, alu_ctl}, 32'h7);
        check("slt result", result, 32'h1);
        check("slt cout", {31'h0, cout}, 32'h0);

        apply(6'b001101, 6'b000000, 32'hF0, 32'hDEAD, 16'h000F);
        check("ori result", result, 32'hFF);
        check("ori alu_ctl", {28'h0, alu_ctl}, 32'h1);
        check("ori slt", {31'h0, slt}, 32'h0);

        apply(6'b001100, 6'b000000, 32'hF0, 32'h0, 16'h003C);
        check("andi result", result, 32'h30);

        apply(6'b001000, 6'b000000, 32'h7FFF_FFFF, 32'h0, 16'h0001);
        check("addi result", result, 32'h8000_0000);
        check("addi overflow", {31'h0, overflow}, 32'h1);

        apply(6'b000000, 6'b100111, 32'h0F0F_0000, 32'h0000_00FF, 16'h0);
        check("nor result", result, 32'hF0F0_FF00);
        check("nor cout", {31'h0, cout}, 32'h0);
        next_edge();
        check("nor result_q", result_q, 32'hF0F0_FF00);

        // Asynchronous clear between edges; combinational path stays live.
        apply(6'b111111, 6'b100000, 32'd3, 32'd4, 16'h0);
        rst = 1'b0;
        #1;
        check("async result_q", result_q, 32'h0);
        check("async flags_q", {28'h0, flags_q}, 32'h0);
`ifdef STICKY_OVF_EN
        check("sticky clr", {31'h0, ovf_sticky}, 32'h0);
`endif
        check("unk ctrl", {22'h0, reg_dst, alu_src, mem_to_reg, reg_write, mem_read, mem_write,
              branch_eq, branch_ne, alu_op}, 32'h0);
        check("unk result live", result, 32'd7);
        next_edge();
        check("held result_q", result_q, 32'h0);

        @(negedge clk);
        rst = 1'b1;
        next_edge();
        check("resume result_q", result_q, 32'd7);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
